// File: rtl/fetch_queue.sv
// fetch_queue: circular buffer of fetched {pc, instr} entries between fetch and decode.
// stall_pc comes from the registered count only, so the PC hold enable has no
// combinational path from push_valid or pop_ready.
// Optional build macro: FETCHQ_BYPASS_EN. When it is defined, an empty queue forwards
// the incoming push straight to out_* in the same cycle.
module fetch_queue #(
  parameter int DEPTH = 4  // must be a power of two, >= 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_valid,
  input  logic [31:0]              push_pc,
  input  logic [31:0]              push_instr,
  input  logic                     flush,
  input  logic                     pop_ready,
  output logic                     stall_pc,
  output logic                     out_valid,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [31:0] IDLE_PC  = 32'h0000_3000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   cnt;

  logic full, stored_valid, push_ok, pop_ok, byp, byp_take, wr_en, rd_en;

  assign full         = (cnt == FULL_CNT);
  assign stall_pc     = full;
  assign count        = cnt;
  assign stored_valid = (cnt != '0) && !flush;
  assign push_ok      = push_valid && !flush && !full;

`ifdef FETCHQ_BYPASS_EN
  // Empty queue: present the incoming fetch directly to decode.
  assign byp      = (cnt == '0) && !flush && push_valid;
`else
  assign byp      = 1'b0;
`endif
  assign out_valid = stored_valid || byp;
  assign pop_ok    = out_valid && pop_ready && !flush;
  // A bypassed entry taken by decode in the same cycle is never stored.
  assign byp_take  = byp && pop_ready;
  assign wr_en     = push_ok && !byp_take;
  assign rd_en     = pop_ok && !byp_take;

  // Head-of-queue output mux; idle value is a nop at the reset PC.
  always_comb begin
    out_pc    = IDLE_PC;
    out_instr = 32'h0;
    if (byp) begin
      out_pc    = push_pc;
      out_instr = push_instr;
    end else if (stored_valid) begin
      out_pc    = mem[rptr].pc;
      out_instr = mem[rptr].instr;
    end
  end

  // Entry storage; contents are don't-care while the slot is unoccupied.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wptr] <= '{pc: push_pc, instr: push_instr};
  end

  // Pointers and occupancy; flush wins over any push/pop in the same cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else if (flush) begin
      wptr <= '0;
      rptr <= '0;
      cnt  <= '0;
    end else begin
      if (wr_en) wptr <= wptr + 1'b1;
      if (rd_en) rptr <= rptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed + random stimulus against a queue-based reference model.
module tb_fetch_queue;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          push_valid, flush, pop_ready;
  logic [31:0]   push_pc, push_instr;
  logic          stall_pc, out_valid;
  logic [31:0]   out_pc, out_instr;
  logic [CW-1:0] count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } ent_t;
  ent_t q[$];

  fetch_queue #(.DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .push_valid(push_valid), .push_pc(push_pc),
    .push_instr(push_instr), .flush(flush), .pop_ready(pop_ready),
    .stall_pc(stall_pc), .out_valid(out_valid), .out_pc(out_pc),
    .out_instr(out_instr), .count(count)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endfunction

  // Compare every output against the model for the currently driven inputs.
  function automatic void check_outputs(input string tag);
    logic        ev;
    logic [31:0] epc, ein;
    ev  = !flush && (q.size() != 0);
    epc = ev ? q[0].pc    : 32'h0000_3000;
    ein = ev ? q[0].instr : 32'h0;
`ifdef FETCHQ_BYPASS_EN
    if (!flush && q.size() == 0 && push_valid) begin
      ev = 1'b1; epc = push_pc; ein = push_instr;
    end
`endif
    chk({tag, ".count"},     64'(count),     64'(q.size()));
    chk({tag, ".stall_pc"},  64'(stall_pc),  64'(q.size() == DEPTH));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, ".out_pc"},    64'(out_pc),    64'(epc));
    chk({tag, ".out_instr"}, 64'(out_instr), 64'(ein));
  endfunction

  // Advance the model by one clock edge using the driven inputs.
  function automatic void model_edge();
    logic bypass_hit, do_pop, do_push;
    if (flush) begin
      q.delete();
      return;
    end
    do_push = push_valid && (q.size() < DEPTH);
    do_pop  = pop_ready && (q.size() != 0);
    bypass_hit = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    bypass_hit = (q.size() == 0) && push_valid && pop_ready;
`endif
    if (bypass_hit) return;
    if (do_pop) void'(q.pop_front());
    if (do_push) q.push_back('{pc: push_pc, instr: push_instr});
  endfunction

  // One cycle: drive at posedge+1, check mid-cycle, clock, return at posedge+1.
  task automatic cyc(input string tag, input logic pv, input logic [31:0] pc,
                     input logic [31:0] ins, input logic fl, input logic pr);
    push_valid = pv; push_pc = pc; push_instr = ins; flush = fl; pop_ready = pr;
    #2;
    check_outputs(tag);
    model_edge();
    @(posedge clk); #1;
  endtask

  initial begin
    reset = 1'b1; push_valid = 0; push_pc = 0; push_instr = 0; flush = 0; pop_ready = 0;
    #1;
    check_outputs("reset");
    @(posedge clk); #1;
    reset = 1'b0;

    // Fill to full, then a fifth push must be ignored.
    for (int i = 0; i < 4; i++)
      cyc("fill", 1, 32'h3000 + 32'(i*4), 32'hA000 + 32'(i), 0, 0);
    chk("fill.full_count", 64'(count), 64'd4);
    chk("fill.stall", 64'(stall_pc), 64'd1);
    cyc("fill5", 1, 32'h3010, 32'hA004, 0, 0);
    chk("fill5.count", 64'(count), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      push_valid = 0; pop_ready = 1; flush = 0; #2;
      chk("drain.order", 64'(out_pc), 64'(32'h3000 + 32'(i*4)));
      #(-0); @(posedge clk); #1;
      void'(q.pop_front());
    end
    pop_ready = 0; #2;
    check_outputs("drained");
    chk("drained.pc", 64'(out_pc), 64'h3000);
    @(posedge clk); #1;

    // Wrap-around with occupancy held at 2.
    cyc("wrap.pre0", 1, 32'h5000, 32'h1, 0, 0);
    cyc("wrap.pre1", 1, 32'h5004, 32'h2, 0, 0);
    for (int i = 0; i < 10; i++) begin
      cyc("wrap", 1, 32'h5008 + 32'(i*4), 32'h3 + 32'(i), 0, 1);
      chk("wrap.count", 64'(count), 64'd2);
    end
    cyc("wrap.flush", 0, 0, 0, 1, 0);

    // Flush with concurrent push and pop.
    for (int i = 0; i < 3; i++) cyc("fl.fill", 1, 32'h6000 + 32'(i*4), 32'h7, 0, 0);
    cyc("fl.flush", 1, 32'h4000, 32'hDEAD, 1, 1);
    chk("fl.count", 64'(count), 64'd0);
    chk("fl.valid", 64'(out_valid), 64'd0);
    cyc("fl.after", 0, 0, 0, 0, 1);

    // Asynchronous reset between edges.
    for (int i = 0; i < 3; i++) cyc("ar.fill", 1, 32'h7000 + 32'(i*4), 32'h9, 0, 0);
    push_valid = 0; pop_ready = 0;
    #2 reset = 1'b1;
    #1;
    chk("ar.count", 64'(count), 64'd0);
    chk("ar.valid", 64'(out_valid), 64'd0);
    chk("ar.pc", 64'(out_pc), 64'h3000);
    q.delete();
    #1 reset = 1'b0;
    @(posedge clk); #1;
    cyc("ar.push", 1, 32'h3020, 32'h55, 0, 0);
    chk("ar.first", 64'(out_pc), 64'h3020);
    cyc("ar.pop", 0, 0, 0, 0, 1);

    // Bypass scenario on an empty queue.
    push_valid = 1; push_pc = 32'h3040; push_instr = 32'h2402_0001; pop_ready = 1; flush = 0;
    #2;
    check_outputs("byp");
`ifdef FETCHQ_BYPASS_EN
    chk("byp.valid_same", 64'(out_valid), 64'd1);
`else
    chk("byp.valid_same", 64'(out_valid), 64'd0);
`endif
    model_edge();
    @(posedge clk); #1;
`ifdef FETCHQ_BYPASS_EN
    chk("byp.count", 64'(count), 64'd0);
`else
    chk("byp.count", 64'(count), 64'd1);
`endif
    cyc("byp.next", 0, 0, 0, 0, 1);

    // Randomized traffic.
    for (int i = 0; i < 400; i++)
      cyc("rand", ($urandom_range(9) < 7), {$urandom_range(32'hFFFF), 2'b00},
          $urandom, ($urandom_range(19) == 0), ($urandom_range(9) < 6));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
